// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman systolic array controller:
// nucleotide codes, the biased-zero helper and the controller state type.
package sw_pkg;

  // 2-bit nucleotide encoding shared by the query and target streams
  localparam logic [1:0] BASE_A = 2'b00;
  localparam logic [1:0] BASE_G = 2'b01;
  localparam logic [1:0] BASE_T = 2'b10;
  localparam logic [1:0] BASE_C = 2'b11;

  // Controller sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_Q = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  // Scores are carried with an offset of half the range so that the PEs
  // never need signed arithmetic; this is the encoding of a score of 0.
  function automatic int unsigned biased_zero(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/sw_timeout_cnt.sv
// Loadable down-counter with an expire flag. Used to bound how long the
// controller waits for the tail PE after the target stream has ended.
module sw_timeout_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins over decrement, and the counter parks at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/sw_array_ctrl.sv
// Sequencer for a linear systolic array of Smith-Waterman PEs. For each
// alignment it releases the array from reset, writes one query base per PE,
// streams the target into the head PE, then waits for the tail PE to flag
// its final high score and captures it. Every output is a register.
module sw_array_ctrl
  import sw_pkg::*;
#(
  parameter int SCORE_WIDTH = 12,
  parameter int N_PE        = 8,
  parameter int TLEN_W      = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    q_valid,
  output logic                    q_ready,
  input  logic [1:0]              q_base,
  input  logic                    t_valid,
  output logic                    t_ready,
  input  logic [1:0]              t_base,
  input  logic                    t_last,
  output logic                    arr_rst_n,
  output logic                    q_we,
  output logic [$clog2(N_PE)-1:0] q_addr,
  output logic [1:0]              q_data,
  output logic                    pe_en,
  output logic [1:0]              pe_data,
  output logic [SCORE_WIDTH-1:0]  pe_m,
  output logic [SCORE_WIDTH-1:0]  pe_i,
  output logic [SCORE_WIDTH-1:0]  pe_high,
  input  logic                    tail_vld,
  input  logic [SCORE_WIDTH-1:0]  tail_high,
  output logic                    busy,
  output logic [SCORE_WIDTH-1:0]  score,
  output logic                    score_valid,
  output logic                    err
);

  localparam int QW    = $clog2(N_PE);
  localparam int TMO_W = $clog2(N_PE + 4);

  localparam logic [SCORE_WIDTH-1:0] ZERO = SCORE_WIDTH'(biased_zero(SCORE_WIDTH));
  localparam logic [QW-1:0]          QCNT_LAST = QW'(N_PE - 1);
  // Index of the last beat that still fits: the target never exceeds
  // 2**TLEN_W-1 bases, so tcnt never has to wrap.
  localparam logic [TLEN_W-1:0]      TCNT_SAT  = {{(TLEN_W-1){1'b1}}, 1'b0};
  // The tail raises vld N_PE cycles after the head enable falls; the extra
  // margin covers the final beat still in flight when DRAIN is entered.
  localparam logic [TMO_W-1:0]       TMO_LOAD  = TMO_W'(N_PE + 3);

  state_e state_q, state_d;

  logic [QW-1:0]          qcnt_q, qcnt_d;
  logic [TLEN_W-1:0]      tcnt_q, tcnt_d;
  logic                   started_q, started_d;
  logic                   q_ready_q, q_ready_d;
  logic                   t_ready_q, t_ready_d;
  logic                   arr_rst_n_q, arr_rst_n_d;
  logic                   q_we_q, q_we_d;
  logic [QW-1:0]          q_addr_q, q_addr_d;
  logic [1:0]             q_data_q, q_data_d;
  logic                   pe_en_q, pe_en_d;
  logic [1:0]             pe_data_q, pe_data_d;
  logic                   busy_q, busy_d;
  logic [SCORE_WIDTH-1:0] score_q, score_d;
  logic                   score_valid_q, score_valid_d;
  logic                   err_q, err_d;

  logic q_beat;
  logic t_beat;
  logic tmo_load;
  logic tmo_expired;

  assign q_beat = q_valid & q_ready_q;
  assign t_beat = t_valid & t_ready_q;

  // Bounds the wait for the tail PE while in DRAIN
  sw_timeout_cnt #(
    .W (TMO_W)
  ) u_timeout (
    .clk        (clk),
    .rst_n      (rst),
    .load_i     (tmo_load),
    .load_val_i (TMO_LOAD),
    .en_i       (state_q == DRAIN),
    .expired_o  (tmo_expired)
  );

  // Next-state and next-output decode for the alignment sequence
  always_comb begin
    // NOTE: every signal assigned here takes a default first so that no path
    // through the case leaves it unassigned and infers a latch.
    state_d       = state_q;
    qcnt_d        = qcnt_q;
    tcnt_d        = tcnt_q;
    started_d     = started_q;
    q_ready_d     = q_ready_q;
    t_ready_d     = t_ready_q;
    arr_rst_n_d   = arr_rst_n_q;
    q_addr_d      = q_addr_q;
    q_data_d      = q_data_q;
    pe_data_d     = pe_data_q;
    busy_d        = busy_q;
    score_d       = score_q;
    err_d         = err_q;
    q_we_d        = 1'b0;
    pe_en_d       = 1'b0;
    score_valid_d = 1'b0;
    tmo_load      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD_Q;
          err_d       = 1'b0;
          qcnt_d      = '0;
          arr_rst_n_d = 1'b1;
          busy_d      = 1'b1;
          q_ready_d   = 1'b1;
        end
      end

      LOAD_Q: begin
        if (q_beat) begin
          q_we_d   = 1'b1;
          q_addr_d = qcnt_q;
          q_data_d = q_base;
          qcnt_d   = qcnt_q + 1'b1;
          if (qcnt_q == QCNT_LAST) begin
            state_d   = STREAM;
            q_ready_d = 1'b0;
            t_ready_d = 1'b1;
            tcnt_d    = '0;
            started_d = 1'b0;
          end
        end
      end

      STREAM: begin
        if (t_beat) begin
          pe_en_d   = 1'b1;
          pe_data_d = t_base;
          tcnt_d    = tcnt_q + 1'b1;
          started_d = 1'b1;
          if (t_last || (tcnt_q == TCNT_SAT)) begin
            // An over-length target still delivers its last beat
            err_d     = err_q | ~t_last;
            state_d   = DRAIN;
            t_ready_d = 1'b0;
            tmo_load  = 1'b1;
          end
        end else if (started_q) begin
          // Once streaming, the array cannot be stalled: a gap ends the target
          err_d     = 1'b1;
          state_d   = DRAIN;
          t_ready_d = 1'b0;
          tmo_load  = 1'b1;
        end
      end

      DRAIN: begin
        if (tail_vld) begin
          score_d       = tail_high;
          score_valid_d = 1'b1;
          state_d       = IDLE;
          busy_d        = 1'b0;
          arr_rst_n_d   = 1'b0;
        end else if (tmo_expired) begin
          err_d       = 1'b1;
          state_d     = IDLE;
          busy_d      = 1'b0;
          arr_rst_n_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset parks the array in reset and idle
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    if (!rst) begin
      state_q       <= IDLE;
      qcnt_q        <= '0;
      tcnt_q        <= '0;
      started_q     <= 1'b0;
      q_ready_q     <= 1'b0;
      t_ready_q     <= 1'b0;
      arr_rst_n_q   <= 1'b0;
      q_we_q        <= 1'b0;
      q_addr_q      <= '0;
      q_data_q      <= '0;
      pe_en_q       <= 1'b0;
      pe_data_q     <= '0;
      busy_q        <= 1'b0;
      score_q       <= ZERO;
      score_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      qcnt_q        <= qcnt_d;
      tcnt_q        <= tcnt_d;
      started_q     <= started_d;
      q_ready_q     <= q_ready_d;
      t_ready_q     <= t_ready_d;
      arr_rst_n_q   <= arr_rst_n_d;
      q_we_q        <= q_we_d;
      q_addr_q      <= q_addr_d;
      q_data_q      <= q_data_d;
      pe_en_q       <= pe_en_d;
      pe_data_q     <= pe_data_d;
      busy_q        <= busy_d;
      score_q       <= score_d;
      score_valid_q <= score_valid_d;
      err_q         <= err_d;
    end
  end

  assign q_ready     = q_ready_q;
  assign t_ready     = t_ready_q;
  assign arr_rst_n   = arr_rst_n_q;
  assign q_we        = q_we_q;
  assign q_addr      = q_addr_q;
  assign q_data      = q_data_q;
  assign pe_en       = pe_en_q;
  assign pe_data     = pe_data_q;
  assign busy        = busy_q;
  assign score       = score_q;
  assign score_valid = score_valid_q;
  assign err         = err_q;

  // The head PE's left neighbour is a permanent boundary of biased zeros
  assign pe_m    = ZERO;
  assign pe_i    = ZERO;
  assign pe_high = ZERO;

endmodule

// File: tb/tb_sw_array_ctrl.sv
// Scoreboard bench for sw_array_ctrl with N_PE=4, SCORE_WIDTH=12, TLEN_W=4.
// Inputs change on the falling edge; a falling-edge monitor pops expected
// query writes, head-PE beats and captured scores as the DUT emits them.
module tb_sw_array_ctrl;
  import sw_pkg::*;

  localparam int SW   = 12;
  localparam int NPE  = 4;
  localparam int TLW  = 4;
  localparam logic [SW-1:0] ZERO_V = 12'd2048;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, q_valid, t_valid, t_last, tail_vld;
  logic [1:0]    q_base, t_base;
  logic [SW-1:0] tail_high;
  logic          q_ready, t_ready, arr_rst_n, q_we, pe_en;
  logic [1:0]    q_addr, q_data, pe_data;
  logic [SW-1:0] pe_m, pe_i, pe_high, score;
  logic          busy, score_valid, err;

  int n_cmp = 0;
  int n_mis = 0;

  logic [3:0]    q_exp[$];   // {addr, base}
  logic [1:0]    t_exp[$];
  logic [SW-1:0] sc_exp[$];
  logic [SW-1:0] last_score;

  sw_array_ctrl #(
    .SCORE_WIDTH (SW),
    .N_PE        (NPE),
    .TLEN_W      (TLW)
  ) dut (
    .clk         (clk),
    .rst         (rst_n),
    .start       (start),
    .q_valid     (q_valid),
    .q_ready     (q_ready),
    .q_base      (q_base),
    .t_valid     (t_valid),
    .t_ready     (t_ready),
    .t_base      (t_base),
    .t_last      (t_last),
    .arr_rst_n   (arr_rst_n),
    .q_we        (q_we),
    .q_addr      (q_addr),
    .q_data      (q_data),
    .pe_en       (pe_en),
    .pe_data     (pe_data),
    .pe_m        (pe_m),
    .pe_i        (pe_i),
    .pe_high     (pe_high),
    .tail_vld    (tail_vld),
    .tail_high   (tail_high),
    .busy        (busy),
    .score       (score),
    .score_valid (score_valid),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Scoreboard monitor
  logic [3:0] qe;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (q_we) begin
        if (q_exp.size() == 0) check("q_we_unexpected", q_we, 0);
        else begin
          qe = q_exp.pop_front();
          check("q_addr", q_addr, qe[3:2]);
          check("q_data", q_data, qe[1:0]);
        end
      end
      if (pe_en) begin
        if (t_exp.size() == 0) check("pe_en_unexpected", pe_en, 0);
        else check("pe_data", pe_data, t_exp.pop_front());
      end
      if (score_valid) begin
        if (sc_exp.size() == 0) check("score_valid_unexpected", score_valid, 0);
        else check("score", score, sc_exp.pop_front());
      end
    end
  end

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("q_ready_after_start", q_ready, 1);
    check("arr_rst_n_after_start", arr_rst_n, 1);
    check("err_cleared_on_start", err, 0);
  endtask

  // Four query bases, base i in bits [2i+1:2i]; optional idle cycle (with a
  // stray start pulse) before beat gap_before.
  task automatic send_query(input logic [7:0] bases, input int gap_before);
    int n;
    for (int i = 0; i < NPE; i++) begin
      if (i == gap_before) begin
        q_valid = 1'b0;
        start   = 1'b1;
        cyc();
        start   = 1'b0;
      end
      n = 0;
      while (!q_ready && n < 20) begin cyc(); n++; end
      check("q_ready_wait", q_ready, 1);
      q_valid = 1'b1;
      q_base  = bases[2*i +: 2];
      q_exp.push_back({2'(i), bases[2*i +: 2]});
      cyc();
    end
    q_valid = 1'b0;
    check("q_ready_low_in_stream", q_ready, 0);
    check("t_ready_high_in_stream", t_ready, 1);
  endtask

  task automatic send_target(input int nb, input bit last, input int pre_gap,
                             input logic [29:0] bases);
    int n;
    for (int g = 0; g < pre_gap; g++) begin
      t_valid = 1'b0;
      cyc();
      check("pe_en_idle_before_first", pe_en, 0);
      check("err_before_first", err, 0);
    end
    for (int i = 0; i < nb; i++) begin
      n = 0;
      while (!t_ready && n < 20) begin cyc(); n++; end
      check("t_ready_wait", t_ready, 1);
      t_valid = 1'b1;
      t_base  = bases[2*i +: 2];
      t_last  = last && (i == nb - 1);
      t_exp.push_back(bases[2*i +: 2]);
      cyc();
    end
    t_valid = 1'b0;
    t_last  = 1'b0;
  endtask

  task automatic drain_score(input int delay, input logic [SW-1:0] high);
    repeat (delay) cyc();
    tail_vld  = 1'b1;
    tail_high = high;
    sc_exp.push_back(high);
    cyc();
    tail_vld  = 1'b0;
    check("score_valid_latency", score_valid, 1);
    check("busy_after_score", busy, 0);
    check("arr_rst_n_after_score", arr_rst_n, 0);
    last_score = high;
    cyc();
    check("score_valid_one_cycle", score_valid, 0);
    check("score_held", score, high);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [29:0] tb;
    int n;
    rst_n = 1'b0; start = 1'b0; q_valid = 1'b0; t_valid = 1'b0; t_last = 1'b0;
    tail_vld = 1'b0; q_base = '0; t_base = '0; tail_high = '0;
    last_score = ZERO_V;
    repeat (3) cyc();

    // Reset values
    check("rst_q_ready", q_ready, 0);
    check("rst_t_ready", t_ready, 0);
    check("rst_q_we", q_we, 0);
    check("rst_pe_en", pe_en, 0);
    check("rst_busy", busy, 0);
    check("rst_score_valid", score_valid, 0);
    check("rst_err", err, 0);
    check("rst_arr_rst_n", arr_rst_n, 0);
    check("rst_q_addr", q_addr, 0);
    check("rst_q_data", q_data, 0);
    check("rst_pe_data", pe_data, 0);
    check("rst_score", score, ZERO_V);
    check("rst_pe_m", pe_m, ZERO_V);
    check("rst_pe_i", pe_i, ZERO_V);
    check("rst_pe_high", pe_high, ZERO_V);
    rst_n = 1'b1;
    cyc();

    // tail_vld in IDLE must be ignored
    tail_vld = 1'b1; tail_high = 12'd999;
    cyc();
    tail_vld = 1'b0;
    check("idle_tail_vld_ignored", score_valid, 0);
    cyc();
    check("idle_score_unchanged", score, ZERO_V);

    // 1+2: query ACGT with a gap, target ACGT with t_last
    do_start();
    send_query({BASE_T, BASE_G, BASE_C, BASE_A}, 2);
    send_target(4, 1'b1, 2, {22'd0, BASE_T, BASE_G, BASE_C, BASE_A});
    check("t2_t_ready_off", t_ready, 0);
    check("t2_busy_drain", busy, 1);
    cyc();
    check("t2_pe_en_fell", pe_en, 0);
    start = 1'b1;   // ignored while busy
    cyc();
    start = 1'b0;
    drain_score(2, 12'd2056);
    check("t2_err", err, 0);

    // 3: t_valid gap after two beats
    do_start();
    send_query({BASE_A, BASE_A, BASE_C, BASE_G}, -1);
    send_target(2, 1'b0, 0, {26'd0, BASE_C, BASE_A});
    cyc();
    check("t3_pe_en_fell", pe_en, 0);
    check("t3_err", err, 1);
    check("t3_t_ready_off", t_ready, 0);
    check("t3_busy_drain", busy, 1);
    drain_score(4, 12'd2051);
    check("t3_err_sticky", err, 1);

    // 4: tail never responds -> timeout after N_PE+4 DRAIN cycles
    do_start();
    send_query({BASE_G, BASE_T, BASE_T, BASE_C}, -1);
    send_target(3, 1'b1, 0, {24'd0, BASE_G, BASE_T, BASE_A});
    n = 0;
    while (busy && n < 30) begin n++; cyc(); end
    check("t4_drain_cycles", n, NPE + 4);
    check("t4_err", err, 1);
    check("t4_score_kept", score, last_score);
    cyc();
    check("t4_no_score_valid", score_valid, 0);

    // 5: 15 beats with no t_last -> saturation
    do_start();
    send_query({BASE_A, BASE_G, BASE_T, BASE_T}, -1);
    for (int i = 0; i < 15; i++) tb[2*i +: 2] = 2'($urandom_range(0, 3));
    send_target(15, 1'b0, 0, tb);
    check("t5_t_ready_off", t_ready, 0);
    check("t5_err", err, 1);
    check("t5_busy", busy, 1);
    t_valid = 1'b1; t_base = BASE_C;   // offered 16th beat must not be taken
    cyc();
    t_valid = 1'b0;
    check("t5_no_16th_beat", pe_en, 0);
    check("t5_t_ready_still_off", t_ready, 0);
    drain_score(1, 12'd2100);

    // 6: reset in the middle of STREAM
    do_start();
    send_query({BASE_C, BASE_C, BASE_A, BASE_G}, -1);
    send_target(2, 1'b0, 0, {26'd0, BASE_G, BASE_T});
    #2 rst_n = 1'b0;
    #1;
    check("t6_pe_en", pe_en, 0);
    check("t6_arr_rst_n", arr_rst_n, 0);
    check("t6_busy", busy, 0);
    check("t6_score", score, ZERO_V);
    check("t6_t_ready", t_ready, 0);
    check("t6_err", err, 0);
    last_score = ZERO_V;
    cyc();
    rst_n = 1'b1;
    cyc();
    check("t6_idle_after_reset", busy, 0);

    // 1-base target with t_last on the first beat is legal
    do_start();
    send_query({BASE_T, BASE_A, BASE_G, BASE_C}, -1);
    send_target(1, 1'b1, 1, {28'd0, BASE_G});
    check("t7_t_ready_off", t_ready, 0);
    check("t7_err", err, 0);
    drain_score(3, 12'd2049);
    check("t7_err_after", err, 0);
    check("end_pe_m", pe_m, ZERO_V);

    cyc();
    check("q_exp_drained", q_exp.size(), 0);
    check("t_exp_drained", t_exp.size(), 0);
    check("sc_exp_drained", sc_exp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
